// File: rtl/fifo_1r1w_flex.sv
// Single-clock FIFO with arbitrary depth and first-word-fall-through output.
// Provides an occupancy count and registered almost-full/almost-empty flags.
module fifo_1r1w_flex #(
    parameter int width_p        = 8,
    parameter int depth_p        = 12,
    parameter int almost_full_p  = depth_p - 2,
    parameter int almost_empty_p = 1
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic [width_p-1:0]           data_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    output logic                         valid_o,
    output logic [width_p-1:0]           data_o,
    input  logic                         ready_i,
    output logic [$clog2(depth_p+1)-1:0] count_o,
    output logic                         almost_full_o,
    output logic                         almost_empty_o
);

    localparam int cw_lp = $clog2(depth_p + 1);
    localparam int pw_lp = $clog2(depth_p);

    localparam logic [cw_lp-1:0] depth_c = cw_lp'(depth_p);
    localparam logic [cw_lp-1:0] af_c    = cw_lp'(almost_full_p);
    localparam logic [cw_lp-1:0] ae_c    = cw_lp'(almost_empty_p);
    localparam logic [pw_lp-1:0] last_c  = pw_lp'(depth_p - 1);

    logic [width_p-1:0] mem_q [depth_p];
    logic [pw_lp-1:0]   wr_ptr_q;
    logic [pw_lp-1:0]   rd_ptr_q;
    logic [cw_lp-1:0]   count_q;
    logic [cw_lp-1:0]   count_n;
    logic               almost_full_q;
    logic               almost_empty_q;
    logic               push;
    logic               pop;

    // Handshake outputs come only from the count register, never from valid_i/ready_i.
    assign ready_o = (count_q != depth_c);
    assign valid_o = (count_q != '0);
    assign push    = valid_i & ready_o;
    assign pop     = valid_o & ready_i;

    assign data_o         = mem_q[rd_ptr_q];
    assign count_o        = count_q;
    assign almost_full_o  = almost_full_q;
    assign almost_empty_o = almost_empty_q;

    always_comb begin
        count_n = count_q;
        if (push && !pop) begin
            count_n = count_q + cw_lp'(1);
        end else if (pop && !push) begin
            count_n = count_q - cw_lp'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointers wrap by explicit compare so non-power-of-two depths work.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            almost_full_q  <= (af_c == '0);
            almost_empty_q <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == last_c) ? '0 : wr_ptr_q + pw_lp'(1);
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == last_c) ? '0 : rd_ptr_q + pw_lp'(1);
            end
            count_q        <= count_n;
            almost_full_q  <= (count_n >= af_c);
            almost_empty_q <= (count_n <= ae_c);
        end
    end

endmodule

// File: tb/tb_fifo_1r1w_flex.sv
// Bench for fifo_1r1w_flex: constant vector table, directed corner cases,
// and randomized traffic checked against a queue-based reference.
module tb_fifo_1r1w_flex;

    localparam int W  = 8;
    localparam int D  = 12;
    localparam int AF = 10;
    localparam int AE = 1;

    logic         clk_i = 1'b0;
    logic         reset_i;
    logic [W-1:0] data_i;
    logic         valid_i;
    logic         ready_o;
    logic         valid_o;
    logic [W-1:0] data_o;
    logic         ready_i;
    logic [3:0]   count_o;
    logic         almost_full_o;
    logic         almost_empty_o;

    fifo_1r1w_flex #(
        .width_p(W), .depth_p(D), .almost_full_p(AF), .almost_empty_p(AE)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
        .valid_o(valid_o), .data_o(data_o), .ready_i(ready_i),
        .count_o(count_o), .almost_full_o(almost_full_o), .almost_empty_o(almost_empty_o)
    );

    always #5 clk_i = ~clk_i;

    int n_pass  = 0;
    int n_total = 0;

    logic [W-1:0] model_q[$];

    typedef struct {
        logic       rst;
        logic       vin;
        logic [7:0] din;
        logic       rin;
        logic [3:0] cnt;
        logic       vout;
        logic       rout;
        logic [7:0] dout;
        logic       af;
        logic       ae;
    } vec_t;

    localparam int NV = 31;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Apply one cycle of inputs, advance the reference, then sample 1 time unit after the edge.
    task automatic cycle(input logic rst, input logic v, input logic [7:0] d, input logic r);
        reset_i = rst;
        valid_i = v;
        data_i  = d;
        ready_i = r;
        if (rst) begin
            model_q.delete();
        end else begin
            bit do_pop, do_push;
            do_push = v && (model_q.size() < D);
            do_pop  = r && (model_q.size() > 0);
            if (do_pop) void'(model_q.pop_front());
            if (do_push) model_q.push_back(d);
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_model(input string tag);
        int n;
        n = model_q.size();
        check({tag, "_count"}, 32'(count_o), 32'(n));
        check({tag, "_valid"}, 32'(valid_o), 32'(n > 0));
        check({tag, "_ready"}, 32'(ready_o), 32'(n < D));
        check({tag, "_af"}, 32'(almost_full_o), 32'(n >= AF));
        check({tag, "_ae"}, 32'(almost_empty_o), 32'(n <= AE));
        if (n > 0) check({tag, "_data"}, 32'(data_o), 32'(model_q[0]));
    endtask

    initial begin
        // Reset, five idle cycles, fill 0x01..0x0C, held-off 0xFF, drain.
        vecs[0] = '{1, 0, 8'h00, 0, 4'd0, 0, 1, 8'h00, 0, 1};
        for (int i = 1; i <= 5; i++) vecs[i] = '{0, 0, 8'h00, 0, 4'd0, 0, 1, 8'h00, 0, 1};
        for (int k = 1; k <= 12; k++)
            vecs[5+k] = '{0, 1, 8'(k), 0, 4'(k), 1, (k < 12), 8'h01, (k >= 10), (k <= 1)};
        vecs[18] = '{0, 1, 8'hFF, 0, 4'd12, 1, 0, 8'h01, 1, 0};
        for (int k = 1; k <= 12; k++)
            vecs[18+k] = '{0, 0, 8'h00, 1, 4'(12-k), (k < 12), 1, 8'(k+1),
                           ((12-k) >= 10), ((12-k) <= 1)};

        for (int i = 0; i < NV; i++) begin
            cycle(vecs[i].rst, vecs[i].vin, vecs[i].din, vecs[i].rin);
            check($sformatf("tbl%0d_count", i), 32'(count_o), 32'(vecs[i].cnt));
            check($sformatf("tbl%0d_valid", i), 32'(valid_o), 32'(vecs[i].vout));
            check($sformatf("tbl%0d_ready", i), 32'(ready_o), 32'(vecs[i].rout));
            check($sformatf("tbl%0d_af", i), 32'(almost_full_o), 32'(vecs[i].af));
            check($sformatf("tbl%0d_ae", i), 32'(almost_empty_o), 32'(vecs[i].ae));
            if (vecs[i].vout) check($sformatf("tbl%0d_data", i), 32'(data_o), 32'(vecs[i].dout));
        end

        // Push into an empty FIFO while the consumer is ready: no same-cycle fall-through.
        reset_i = 0; valid_i = 1; data_i = 8'hA5; ready_i = 1;
        #1;
        check("empty_edge_valid_before", 32'(valid_o), 32'd0);
        cycle(0, 1, 8'hA5, 1);
        check("empty_edge_valid_after", 32'(valid_o), 32'd1);
        check("empty_edge_data_after", 32'(data_o), 32'hA5);
        check_model("empty_edge");

        // Bring occupancy to 5, then stream 40 push+pop cycles across pointer wraps.
        for (int k = 1; k <= 4; k++) cycle(0, 1, 8'(8'h10 + k), 0);
        check_model("wrap_prefill");
        begin
            logic [7:0] expect_q[$];
            expect_q = '{8'hA5, 8'h11, 8'h12, 8'h13, 8'h14};
            for (int k = 0; k < 40; k++) begin
                logic [7:0] d;
                d = 8'(8'h40 + k);
                reset_i = 0; valid_i = 1; data_i = d; ready_i = 1;
                #1;
                check("wrap_head", 32'(data_o), 32'(expect_q[0]));
                void'(expect_q.pop_front());
                expect_q.push_back(d);
                cycle(0, 1, d, 1);
                check("wrap_count", 32'(count_o), 32'd5);
            end
        end
        check_model("wrap_end");

        // Fill to full, then pop with a concurrent write that must be refused.
        for (int k = 0; k < 7; k++) cycle(0, 1, 8'(8'h80 + k), 0);
        check("full_edge_count", 32'(count_o), 32'd12);
        reset_i = 0; valid_i = 1; data_i = 8'hEE; ready_i = 1;
        #1;
        check("full_edge_ready_before", 32'(ready_o), 32'd0);
        cycle(0, 1, 8'hEE, 1);
        check("full_edge_count_after", 32'(count_o), 32'd11);
        check("full_edge_ready_after", 32'(ready_o), 32'd1);
        check_model("full_edge");

        // Drain to 7, then reset while pushing and popping.
        for (int k = 0; k < 4; k++) cycle(0, 0, 8'h00, 1);
        check("pre_reset_count", 32'(count_o), 32'd7);
        cycle(1, 1, 8'h99, 1);
        check("mid_reset_count", 32'(count_o), 32'd0);
        check("mid_reset_valid", 32'(valid_o), 32'd0);
        check("mid_reset_ready", 32'(ready_o), 32'd1);
        cycle(0, 1, 8'h3C, 0);
        check("post_reset_first", 32'(data_o), 32'h3C);
        check("post_reset_valid", 32'(valid_o), 32'd1);
        check_model("post_reset");

        // Randomized traffic with shifting push/pop bias and rare resets.
        for (int k = 0; k < 3000; k++) begin
            int pv, pr;
            pv = ((k / 300) % 2 == 0) ? 70 : 35;
            pr = ((k / 300) % 2 == 0) ? 35 : 70;
            cycle(($urandom_range(0, 299) == 0),
                  ($urandom_range(0, 99) < pv),
                  8'($urandom),
                  ($urandom_range(0, 99) < pr));
            check_model("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
